// File: rtl/zap_wb_arbiter.sv
// zap_wb_arbiter: two-master (instr/data) to one-slave Wishbone arbiter with round-robin grant and bus-timeout watchdog
module zap_wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_instr_wb_cyc,
    input  logic        i_instr_wb_stb,
    input  logic        i_instr_wb_we,
    input  logic [3:0]  i_instr_wb_sel,
    input  logic [31:0] i_instr_wb_adr,
    input  logic [31:0] i_instr_wb_dat,
    output logic [31:0] o_instr_wb_dat,
    output logic        o_instr_wb_ack,
    output logic        o_instr_wb_err,
    input  logic        i_data_wb_cyc,
    input  logic        i_data_wb_stb,
    input  logic        i_data_wb_we,
    input  logic [3:0]  i_data_wb_sel,
    input  logic [31:0] i_data_wb_adr,
    input  logic [31:0] i_data_wb_dat,
    output logic [31:0] o_data_wb_dat,
    output logic        o_data_wb_ack,
    output logic        o_data_wb_err,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [3:0]  o_wb_sel,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    output logic [1:0]  o_grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_t;

    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;
    localparam bit   TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gnt_i, gnt_d;
    logic              m_cyc, m_stb, m_we;
    logic [3:0]        m_sel;
    logic [31:0]       m_adr, m_dat;
    logic              tmo_hit;

    assign gnt_i = (state_q == GNT_I);
    assign gnt_d = (state_q == GNT_D);

    // State, round-robin history and watchdog counter registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            last_q  <= LAST_I;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: grants held for the whole cyc, handover straight to a waiting master
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                state_d = (i_data_wb_cyc && (!i_instr_wb_cyc || last_q == LAST_I)) ? GNT_D :
                          i_instr_wb_cyc ? GNT_I : IDLE;
            end
            GNT_I: begin
                if (!i_instr_wb_cyc) begin
                    state_d = i_data_wb_cyc ? GNT_D : IDLE;
                    last_d  = LAST_I;
                end
            end
            GNT_D: begin
                if (!i_data_wb_cyc) begin
                    state_d = i_instr_wb_cyc ? GNT_I : IDLE;
                    last_d  = LAST_D;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slave-side mux of the granted master's request, all zero while idle
    always_comb begin
        m_cyc = gnt_i ? i_instr_wb_cyc : gnt_d ? i_data_wb_cyc : 1'b0;
        m_stb = gnt_i ? i_instr_wb_stb : gnt_d ? i_data_wb_stb : 1'b0;
        m_we  = gnt_i ? i_instr_wb_we  : gnt_d ? i_data_wb_we  : 1'b0;
        m_sel = gnt_i ? i_instr_wb_sel : gnt_d ? i_data_wb_sel : 4'h0;
        m_adr = gnt_i ? i_instr_wb_adr : gnt_d ? i_data_wb_adr : 32'h0;
        m_dat = gnt_i ? i_instr_wb_dat : gnt_d ? i_data_wb_dat : 32'h0;
    end

    // Watchdog: count unanswered strobe cycles, fire once at the limit, then restart
    always_comb begin
        tmo_hit = TMO_EN && m_stb && !i_wb_ack && !i_wb_err && (cnt_q == TMO_LAST);
        cnt_d   = (i_wb_ack || i_wb_err || tmo_hit || state_d != state_q) ? '0 :
                  (m_stb && cnt_q != {CNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
    end

    // Outputs: slave request and response routing to the granted master only
    always_comb begin
        o_wb_cyc       = m_cyc;
        o_wb_stb       = m_stb && !tmo_hit;
        o_wb_we        = m_we;
        o_wb_sel       = m_sel;
        o_wb_adr       = m_adr;
        o_wb_dat       = m_dat;
        o_grant        = state_q;
        o_instr_wb_ack = i_wb_ack && !i_wb_err && gnt_i && i_instr_wb_cyc;
        o_instr_wb_err = (i_wb_err || tmo_hit) && gnt_i && i_instr_wb_cyc;
        o_instr_wb_dat = gnt_i ? i_wb_dat : 32'h0;
        o_data_wb_ack  = i_wb_ack && !i_wb_err && gnt_d && i_data_wb_cyc;
        o_data_wb_err  = (i_wb_err || tmo_hit) && gnt_d && i_data_wb_cyc;
        o_data_wb_dat  = gnt_d ? i_wb_dat : 32'h0;
    end

endmodule
